regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the single register-file write port between two writeback requesters: ALU (requester 0) and load/memory unit (requester 1). It accepts one write per cycle through a valid/ready handshake and drives a registered write enable, address and data to the register-file flip-flop array. It suppresses writes to register 0 and counts contention cycles for performance debug.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- CNT_W, 16, contention counter width

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU has a pending writeback
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request granted this cycle
- mem_valid  in  1  memory unit has a pending writeback
- mem_addr  in  ADDR_W  memory destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  memory request granted this cycle
- wb_stall  in  1  register file busy; no grant this cycle
- wb_write  out  1  write enable to register file
- wb_addr  out  ADDR_W  write address
- wb_data  out  DATA_W  write data
- conflict_cnt  out  CNT_W  saturating count of cycles where a valid request was refused

## Operation
- Transfer on requester X occurs when X_valid && X_ready in the same cycle.
- Ready signals are combinational from valids, wb_stall and priority state. At most one ready is high per cycle. Ready is never high for a requester whose valid is low.
- wb_stall high: both readies 0.
- Exactly one valid, no stall: that requester is granted.
- Both valid, no stall: winner chosen by priority state (see Configuration).
- Accepted write is registered: wb_write=1, wb_addr/wb_data = granted addr/data, on the next edge.
- Address 0: the request is still accepted (ready=1), but wb_write stays 0 and the r0 write is dropped.
- No transfer in a cycle: wb_write=0 next cycle. wb_addr/wb_data hold their last values.
- conflict_cnt increments by 1 each cycle with at least one valid requester not granted. This includes all stalled cycles with any valid and the loser of a tie. It saturates at 2^CNT_W-1 and does not wrap.
- Reset values: wb_write=0, wb_addr=0, wb_data=0, conflict_cnt=0, priority pointer = mem preferred.
- Reset mid-operation: a pending registered write is discarded (wb_write=0 on the cycle after reset). Requests present during reset get no grant.

## Timing
- Grant to register-file write: 1 cycle latency, wb_write asserted the cycle after the handshake.
- Throughput: one write per cycle. Back-to-back grants are allowed.
- Requesters must hold valid/addr/data stable until ready. The arbiter does not buffer refused requests.
- Priority pointer (round-robin mode) updates on the edge of a contested grant only. Uncontested grants and stalls leave it unchanged.

## Configuration
- WB_ARB_RR_EN defined: round-robin. A 1-bit pointer names the preferred requester and is reset to mem. On a tie the preferred requester wins, then the pointer flips to the other requester.
- WB_ARB_RR_EN undefined: fixed priority. mem always beats alu on a tie. The pointer flop is absent.
- All other behaviour is identical in both builds.

## Structure
- Shared package regfile_pkg:
  - constants REQ_ALU=0, REQ_MEM=1
  - default widths REG_ADDR_W=5, REG_DATA_W=32
  - typedef for wb request {valid, addr, data}
- Sub-module wb_arb_pick: combinational grant selection from the two valids, wb_stall and the pointer. It produces the ready vector and the winner index.
- Top level holds:
  - output registers
  - pointer register
  - contention counter

## Test plan
- Reset: assert reset 2 cycles with both valid high -> both readies 0, wb_write=0, conflict_cnt=0 after release edge.
- Single ALU write: alu_valid=1, addr=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle wb_write=1, wb_addr=5, wb_data=0xDEADBEEF.
- Tie, RR build: both valid for 4 cycles (addrs 1 and 2) -> grant order mem, alu, mem, alu; conflict_cnt=4. Fixed build: mem granted all 4 cycles.
- Stall: wb_stall=1 for 3 cycles with mem_valid=1 -> no ready, wb_write=0, conflict_cnt +3; stall drops -> mem granted, write 1 cycle later.
- r0 drop: mem_valid=1, addr=0, data=0x1234 -> mem_ready=1, next cycle wb_write=0.
- Saturation: CNT_W=2, both valid 6 cycles -> conflict_cnt reaches 3 and stays 3.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Requester indices double as bit positions in the two-bit valid/ready vectors.
package regfile_pkg;

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_MEM = 1'b1;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles both writeback requesters, the stall input, the register-file write
// port and the contention counter. The master side is the requesters/register file.
interface regfile_wb_arbiter_if #(
   parameter int unsigned DATA_W = regfile_pkg::REG_DATA_W,
   parameter int unsigned ADDR_W = regfile_pkg::REG_ADDR_W,
   parameter int unsigned CNT_W  = 16
);
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic              wb_stall;
   logic              wb_write;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [CNT_W-1:0]  conflict_cnt;

   modport master (
      output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, wb_stall,
      input  alu_ready, mem_ready, wb_write, wb_addr, wb_data, conflict_cnt
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, wb_stall,
      output alu_ready, mem_ready, wb_write, wb_addr, wb_data, conflict_cnt
   );
endinterface

// File: rtl/regfile_wb_arbiter_pick.sv
// Combinational grant selection: at most one ready, never for an idle requester.
// pref_i names the requester that wins when both are valid.
module wb_arb_pick
   import regfile_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       stall_i,
   input  logic       pref_i,
   output logic [1:0] ready_o,
   output logic       win_o
);

   // Winner selection and ready generation.
   always_comb begin
      ready_o = 2'b00;
      win_o   = REQ_MEM;
      if (&valid_i) begin
         win_o = pref_i;
      end else if (valid_i[REQ_ALU]) begin
         win_o = REQ_ALU;
      end else begin
         win_o = REQ_MEM;
      end
      if (!stall_i) begin
         ready_o[win_o] = valid_i[win_o];
      end else begin
         ready_o = 2'b00;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port (ALU vs. load unit).
// Define WB_ARB_RR_EN for round-robin tie breaking; otherwise mem always wins ties.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = REG_DATA_W,
   parameter int unsigned ADDR_W = REG_ADDR_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_wb_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]        valid_s;
   logic [1:0]        ready_s;
   logic              win_s;
   logic              ptr_s;
   logic              hold_s;
   logic              xfer_s;
   logic              refused_s;
   logic              contested_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_data_s;

   logic              wb_write_q, wb_write_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Requests seen while in reset are refused like a stall.
   assign valid_s     = {bus.mem_valid, bus.alu_valid};
   assign hold_s      = bus.wb_stall | reset;
   assign xfer_s      = |ready_s;
   assign refused_s   = |(valid_s & ~ready_s);
   assign contested_s = (&valid_s) & ~hold_s;
   assign sel_addr_s  = (win_s == REQ_MEM) ? bus.mem_addr : bus.alu_addr;
   assign sel_data_s  = (win_s == REQ_MEM) ? bus.mem_data : bus.alu_data;

   wb_arb_pick u_pick (
      .valid_i (valid_s),
      .stall_i (hold_s),
      .pref_i  (ptr_s),
      .ready_o (ready_s),
      .win_o   (win_s)
   );

   assign bus.alu_ready    = ready_s[REQ_ALU];
   assign bus.mem_ready    = ready_s[REQ_MEM];
   assign bus.wb_write     = wb_write_q;
   assign bus.wb_addr      = wb_addr_q;
   assign bus.wb_data      = wb_data_q;
   assign bus.conflict_cnt = cnt_q;

   // Next-state for write port and saturating contention counter.
   always_comb begin
      wb_write_d = xfer_s && (sel_addr_s != '0);
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      cnt_d      = cnt_q;
      if (wb_write_d) begin
         wb_addr_d = sel_addr_s;
         wb_data_d = sel_data_s;
      end else begin
         wb_addr_d = wb_addr_q;
         wb_data_d = wb_data_q;
      end
      if (refused_s && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Output and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_write_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         cnt_q      <= '0;
      end else begin
         wb_write_q <= wb_write_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef WB_ARB_RR_EN
   logic ptr_q, ptr_d;

   // After a contested grant the other requester becomes preferred.
   always_comb begin
      ptr_d = ptr_q;
      if (contested_s) begin
         ptr_d = ~win_s;
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= REQ_MEM;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_s = ptr_q;
`else
   assign ptr_s = REQ_MEM;
`endif

endmodule
